// File: rtl/matcher_pkg.sv
// Shared types for the matcher subsystem: scheduler state encoding, the
// default-width result record and the address width common to matcher/sram.
// Contents: MATCH_ADDR_WIDTH, MATCH_CYC_WIDTH, sched_state_e, match_rsp_t.
package matcher_pkg;

  // Address width shared by the matcher, its SRAMs and the scheduler.
  localparam int MATCH_ADDR_WIDTH = 4;
  // Default width of the per-job RUN-cycle counter.
  localparam int MATCH_CYC_WIDTH  = 8;

  // Scheduler job sequence: one pass through these states per job.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_RUN     = 3'd2,
    ST_REPORT  = 3'd3,
    ST_RECOVER = 3'd4
  } sched_state_e;

  // Result record at the default widths, for blocks that consume responses.
  typedef struct packed {
    logic [MATCH_ADDR_WIDTH-1:0] addr;
    logic                        found;
    logic                        timeout;
    logic [MATCH_CYC_WIDTH-1:0]  cycles;
  } match_rsp_t;

endpackage

// File: rtl/match_req_fifo.sv
// Request queue for the match scheduler: synchronous FIFO of word start
// addresses with full/empty/count flags.
// Latency: a pushed entry is visible at o_head_dat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: clk, rst_n (sync, active-low), i_push/i_push_dat, i_pop,
//        o_head_dat, o_full, o_empty, o_count.
module match_req_fifo #(
  parameter  int DW    = 4,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_head_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [PW:0]   o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_rd_ptr;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_head_dat = r_mem[r_rd_ptr[PW-1:0]];

  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[PW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/match_scheduler.sv
// Job sequencer in front of the matcher: queues word start addresses, runs
// the matcher once per word against the vocab window, guards each run with a
// timeout and returns one result record per job over a valid/ready port.
// Latency: m_cs rises 3 cycles after a request is accepted by an idle block.
// Backpressure: req_ready drops when the queue is full; rsp_ready stalls
// REPORT indefinitely with the record held stable.
// Ports: clk, rst_n (sync, active-low); cfg_vocab_start/end; req_valid/
//        req_ready/req_addr; m_cs, m_*_addr, m_found, m_done; rsp_valid/
//        rsp_ready/rsp_addr/rsp_found/rsp_timeout/rsp_cycles; busy.
module match_scheduler
  import matcher_pkg::*;
#(
  parameter int ADDR_WIDTH     = MATCH_ADDR_WIDTH,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CYC_WIDTH      = MATCH_CYC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cfg_vocab_start,
  input  logic [ADDR_WIDTH-1:0] cfg_vocab_end,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  m_cs,
  output logic [ADDR_WIDTH-1:0] m_vocab_start_addr,
  output logic [ADDR_WIDTH-1:0] m_vocab_end_addr,
  output logic [ADDR_WIDTH-1:0] m_input_start_addr,
  input  logic                  m_found,
  input  logic                  m_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_found,
  output logic                  rsp_timeout,
  output logic [CYC_WIDTH-1:0]  rsp_cycles,
  output logic                  busy
);

  localparam int CNTW = $clog2(QUEUE_DEPTH) + 1;
  // The timeout is tracked by its own counter so the limit stays reachable
  // independently of how narrow the saturating report counter is.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  found;
    logic                  timeout;
    logic [CYC_WIDTH-1:0]  cycles;
  } rsp_rec_t;

  function automatic logic [CYC_WIDTH-1:0] sat_inc(input logic [CYC_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sched_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_job_addr;
  logic [ADDR_WIDTH-1:0] r_job_vs;
  logic [ADDR_WIDTH-1:0] r_job_ve;
  logic [CYC_WIDTH-1:0]  r_cyc;
  logic [TW-1:0]         r_tmo;
  rsp_rec_t              r_rsp;
  logic                  r_rsp_vld;
  logic                  r_m_cs;
  logic [ADDR_WIDTH-1:0] r_m_vs;
  logic [ADDR_WIDTH-1:0] r_m_ve;
  logic [ADDR_WIDTH-1:0] r_m_in;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNTW-1:0]       w_fifo_count;
  logic [ADDR_WIDTH-1:0] w_fifo_head;
  logic                  w_push;
  logic                  w_pop;

  // Held low through reset so nothing is accepted while the queue clears.
  assign req_ready = rst_n & ~w_fifo_full;
  assign w_push    = req_valid & req_ready;
  // The only pop point is the IDLE->LAUNCH transition.
  assign w_pop     = (r_state == ST_IDLE) & ~w_fifo_empty;

  match_req_fifo #(
    .DW    (ADDR_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (req_addr),
    .i_pop      (w_pop),
    .o_head_dat (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_job_addr <= '0;
      r_job_vs   <= '0;
      r_job_ve   <= '0;
      r_cyc      <= '0;
      r_tmo      <= '0;
      r_rsp      <= '0;
      r_rsp_vld  <= 1'b0;
      r_m_cs     <= 1'b0;
      r_m_vs     <= '0;
      r_m_ve     <= '0;
      r_m_in     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            // Window is captured with the job so later cfg writes cannot
            // disturb it.
            r_job_addr <= w_fifo_head;
            r_job_vs   <= cfg_vocab_start;
            r_job_ve   <= cfg_vocab_end;
            r_state    <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          // Addresses change in the same edge m_cs rises, so they are
          // already stable on the matcher's first enabled cycle.
          r_m_in  <= r_job_addr;
          r_m_vs  <= r_job_vs;
          r_m_ve  <= r_job_ve;
          r_cyc   <= '0;
          r_tmo   <= '0;
          r_m_cs  <= 1'b1;
          r_state <= ST_RUN;
        end

        ST_RUN: begin
          if (m_done) begin
            // Count includes the cycle in which done was sampled; done wins
            // over a coincident timeout.
            r_rsp.addr    <= r_job_addr;
            r_rsp.found   <= m_found;
            r_rsp.timeout <= 1'b0;
            r_rsp.cycles  <= sat_inc(r_cyc);
            r_rsp_vld     <= 1'b1;
            r_m_cs        <= 1'b0;
            r_state       <= ST_REPORT;
          end else if (r_tmo == TMO_LAST) begin
            r_rsp.addr    <= r_job_addr;
            r_rsp.found   <= 1'b0;
            r_rsp.timeout <= 1'b1;
            r_rsp.cycles  <= r_cyc;
            r_rsp_vld     <= 1'b1;
            r_m_cs        <= 1'b0;
            r_state       <= ST_REPORT;
          end else begin
            r_cyc <= sat_inc(r_cyc);
            r_tmo <= r_tmo + 1'b1;
          end
        end

        ST_REPORT: begin
          if (rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_state   <= ST_RECOVER;
          end
        end

        // Guarantees the matcher sees m_cs low long enough to return idle.
        ST_RECOVER: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_m_cs    <= 1'b0;
          r_rsp_vld <= 1'b0;
        end
      endcase
    end
  end

  assign m_cs               = r_m_cs;
  assign m_vocab_start_addr = r_m_vs;
  assign m_vocab_end_addr   = r_m_ve;
  assign m_input_start_addr = r_m_in;

  assign rsp_valid   = r_rsp_vld;
  assign rsp_addr    = r_rsp.addr;
  assign rsp_found   = r_rsp.found;
  assign rsp_timeout = r_rsp.timeout;
  assign rsp_cycles  = r_rsp.cycles;

  assign busy = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_match_scheduler.sv
module tb_match_scheduler;

  localparam int AW  = 4;
  localparam int QD  = 4;
  localparam int TMO = 64;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cfg_vocab_start;
  logic [AW-1:0] cfg_vocab_end;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          m_cs;
  logic [AW-1:0] m_vocab_start_addr;
  logic [AW-1:0] m_vocab_end_addr;
  logic [AW-1:0] m_input_start_addr;
  logic          m_found;
  logic          m_done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic          rsp_found;
  logic          rsp_timeout;
  logic [CW-1:0] rsp_cycles;
  logic          busy;

  always #5 clk = ~clk;

  match_scheduler #(
    .ADDR_WIDTH     (AW),
    .QUEUE_DEPTH    (QD),
    .TIMEOUT_CYCLES (TMO),
    .CYC_WIDTH      (CW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_vocab_start    (cfg_vocab_start),
    .cfg_vocab_end      (cfg_vocab_end),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           (req_addr),
    .m_cs               (m_cs),
    .m_vocab_start_addr (m_vocab_start_addr),
    .m_vocab_end_addr   (m_vocab_end_addr),
    .m_input_start_addr (m_input_start_addr),
    .m_found            (m_found),
    .m_done             (m_done),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_addr           (rsp_addr),
    .rsp_found          (rsp_found),
    .rsp_timeout        (rsp_timeout),
    .rsp_cycles         (rsp_cycles),
    .busy               (busy)
  );

  // Expected result of one job, plus how long m_cs should stay high for it.
  typedef struct {
    logic [AW-1:0] addr;
    logic          found;
    logic          timeout;
    logic [CW-1:0] cycles;
    int            mlen;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Matcher behaviour per input word: lat = enabled cycle on which done
  // appears (0 = never), fnd = found flag reported with done.
  int  lat_tab [16];
  bit  fnd_tab [16];
  int  run_cnt = 0;

  int  n_checks = 0;
  int  n_fail   = 0;
  logic [AW-1:0] exp_vs;
  logic [AW-1:0] exp_ve;
  bit  rand_bp = 1'b0;
  int  rsp_seen = 0;

  // Behavioural matcher: counts enabled cycles, raises done on the lat-th.
  always @(posedge clk) begin
    if (!m_cs) run_cnt <= 0;
    else       run_cnt <= run_cnt + 1;
  end

  assign m_done  = m_cs && (lat_tab[m_input_start_addr] != 0) &&
                   (run_cnt + 1 >= lat_tab[m_input_start_addr]);
  assign m_found = m_done && fnd_tab[m_input_start_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference result computed from the job rules: done within the timeout
  // window (ties included) reports the matcher's verdict, otherwise timeout.
  function automatic exp_t model(input logic [AW-1:0] a);
    exp_t e;
    e.addr = a;
    if (lat_tab[a] != 0 && lat_tab[a] <= TMO) begin
      e.found   = fnd_tab[a];
      e.timeout = 1'b0;
      e.cycles  = (lat_tab[a] > 255) ? 8'hFF : CW'(lat_tab[a]);
      e.mlen    = lat_tab[a];
    end else begin
      e.found   = 1'b0;
      e.timeout = 1'b1;
      e.cycles  = CW'(TMO - 1);
      e.mlen    = TMO;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_req(input logic [AW-1:0] a);
    bit acc = 1'b0;
    int n = 0;
    req_addr  = a;
    req_valid = 1'b1;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      n++;
    end
    req_valid = 1'b0;
    if (acc) exp_q.push_back(model(a));
    check("push_accept", 32'(acc), 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy || rsp_valid || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(n < budget), 1);
  endtask

  task automatic wait_mcs(input logic [AW-1:0] a, input int budget);
    int n = 0;
    while (!(m_cs && m_input_start_addr == a) && n < budget) begin
      tick();
      n++;
    end
    check("wait_mcs", 32'(n < budget), 1);
  endtask

  // Response / launch monitor, sampled on the falling edge.
  int            cur_len = 0;
  int            last_len = 0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] p_addr;
  logic          p_found;
  logic          p_tmo;
  logic [CW-1:0] p_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_len    = 0;
      prev_stall = 1'b0;
    end else begin
      if (m_cs) begin
        cur_len++;
        if (cur_len == 1) begin
          check("launch_vstart", 32'(m_vocab_start_addr), 32'(exp_vs));
          check("launch_vend", 32'(m_vocab_end_addr), 32'(exp_ve));
          if (exp_q.size() != 0)
            check("launch_addr", 32'(m_input_start_addr), 32'(exp_q[0].addr));
          else
            check("launch_unexpected", 32'(exp_q.size()), 1);
        end
      end else if (cur_len != 0) begin
        last_len = cur_len;
        cur_len  = 0;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(rsp_valid), 1);
        check("hold_addr", 32'(rsp_addr), 32'(p_addr));
        check("hold_found", 32'(rsp_found), 32'(p_found));
        check("hold_timeout", 32'(rsp_timeout), 32'(p_tmo));
        check("hold_cycles", 32'(rsp_cycles), 32'(p_cyc));
      end
      if (rsp_valid) rsp_seen++;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rsp_addr", 32'(rsp_addr), 32'(mon_e.addr));
          check("rsp_found", 32'(rsp_found), 32'(mon_e.found));
          check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.timeout));
          check("rsp_cycles", 32'(rsp_cycles), 32'(mon_e.cycles));
          check("mcs_len", 32'(last_len), 32'(mon_e.mlen));
        end else begin
          check("rsp_unexpected", 32'(exp_q.size()), 1);
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      p_addr  = rsp_addr;
      p_found = rsp_found;
      p_tmo   = rsp_timeout;
      p_cyc   = rsp_cycles;
    end
  end

  initial begin
    bit any_ready;

    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_addr        = '0;
    cfg_vocab_start = '0;
    cfg_vocab_end   = '0;
    rsp_ready       = 1'b1;
    exp_vs          = '0;
    exp_ve          = '0;
    for (int i = 0; i < 16; i++) begin
      lat_tab[i] = 5;
      fnd_tab[i] = 1'b0;
    end

    // Reset state
    tick();
    tick();
    check("rst_m_cs", 32'(m_cs), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_m_input", 32'(m_input_start_addr), 0);
    check("rst_m_vstart", 32'(m_vocab_start_addr), 0);
    check("rst_m_vend", 32'(m_vocab_end_addr), 0);
    check("rst_rsp_cycles", 32'(rsp_cycles), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 1);
    tick();

    // Single hit with launch latency
    cfg_vocab_start = 4'd0;
    cfg_vocab_end   = 4'd15;
    exp_vs = 4'd0;
    exp_ve = 4'd15;
    lat_tab[0] = 10;
    fnd_tab[0] = 1'b1;
    req_addr  = 4'd0;
    req_valid = 1'b1;
    check("hit_req_ready", 32'(req_ready), 1);
    tick();
    exp_q.push_back(model(4'd0));
    req_valid = 1'b0;
    check("lat_cyc1_m_cs", 32'(m_cs), 0);
    check("lat_cyc1_busy", 32'(busy), 1);
    tick();
    check("lat_cyc2_m_cs", 32'(m_cs), 0);
    tick();
    check("lat_cyc3_m_cs", 32'(m_cs), 1);
    check("hit_m_input", 32'(m_input_start_addr), 0);
    drain(200);
    check("hit_idle_busy", 32'(busy), 0);

    // Miss, reversed window, cfg changed mid-job
    cfg_vocab_start = 4'd9;
    cfg_vocab_end   = 4'd2;
    exp_vs = 4'd9;
    exp_ve = 4'd2;
    lat_tab[4] = 20;
    fnd_tab[4] = 1'b0;
    push_req(4'd4);
    wait_mcs(4'd4, 50);
    cfg_vocab_start = 4'd0;
    cfg_vocab_end   = 4'd0;
    repeat (3) tick();
    check("cfg_hold_vstart", 32'(m_vocab_start_addr), 9);
    check("cfg_hold_vend", 32'(m_vocab_end_addr), 2);
    drain(200);
    check("miss_hold_vstart", 32'(m_vocab_start_addr), 9);
    cfg_vocab_start = 4'd0;
    cfg_vocab_end   = 4'd15;
    exp_vs = 4'd0;
    exp_ve = 4'd15;

    // Queue full under response backpressure
    lat_tab[1] = 3;  fnd_tab[1] = 1'b0;
    lat_tab[2] = 5;  fnd_tab[2] = 1'b1;
    lat_tab[3] = 7;  fnd_tab[3] = 1'b0;
    lat_tab[6] = 4;  fnd_tab[6] = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_req(AW'(i));
    any_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ready) any_ready = 1'b1;
    end
    check("full_req_ready", 32'(any_ready), 0);
    check("full_rsp_valid", 32'(rsp_valid), 1);
    check("full_rsp_addr", 32'(rsp_addr), 0);
    check("full_busy", 32'(busy), 1);
    rsp_ready = 1'b1;
    push_req(4'd6);
    drain(600);

    // Timeout, next job normal; then done/timeout tie; then one past the limit
    lat_tab[7]  = 0;
    lat_tab[8]  = 5;  fnd_tab[8]  = 1'b1;
    lat_tab[9]  = 64; fnd_tab[9]  = 1'b1;
    lat_tab[13] = 65; fnd_tab[13] = 1'b1;
    push_req(4'd7);
    push_req(4'd8);
    drain(400);
    push_req(4'd9);
    drain(200);
    push_req(4'd13);
    drain(200);

    // Reset while job 2 of 3 is running
    lat_tab[10] = 30;
    lat_tab[11] = 30;
    lat_tab[12] = 30;
    push_req(4'd10);
    push_req(4'd11);
    push_req(4'd12);
    wait_mcs(4'd11, 300);
    repeat (5) tick();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_m_cs", 32'(m_cs), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    rsp_seen = 0;
    repeat (100) tick();
    check("midrst_no_stale_rsp", 32'(rsp_seen), 0);
    check("midrst_idle_busy", 32'(busy), 0);

    // Randomized jobs with random backpressure and request gaps
    cfg_vocab_start = AW'($urandom_range(0, 15));
    cfg_vocab_end   = AW'($urandom_range(0, 15));
    exp_vs = cfg_vocab_start;
    exp_ve = cfg_vocab_end;
    for (int i = 0; i < 16; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      lat_tab[i] = 0;
      else if (r == 1) lat_tab[i] = int'($urandom_range(60, 70));
      else             lat_tab[i] = int'($urandom_range(1, 25));
      fnd_tab[i] = 1'($urandom_range(0, 1));
    end
    rand_bp = 1'b1;
    for (int j = 0; j < 30; j++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) tick();
      push_req(AW'($urandom_range(0, 15)));
    end
    drain(5000);
    rand_bp   = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("final_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
